// File: rtl/hs32_pkg.sv
// Shared hs32 front-end types: fetch state, instruction size and address type.
package hs32_pkg;

  localparam int HS32_INSN_BYTES = 4;

  typedef logic [31:0] hs32_addr_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } hs32_fstate_t;

endpackage

// File: rtl/hs32_fetch_fifo.sv
// DEPTH-entry instruction word FIFO with synchronous clear; head is read combinationally.
module hs32_fetch_fifo
  import hs32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  input  logic          i_clear,
  output logic [CW-1:0] o_count,
  output logic [31:0]   o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr] <= i_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch front-end: credit-limited requests, in-order response buffering,
// redirect flush, halt and sticky fetch fault. Define HS32_FETCH_PERF_EN for perf counters.
module hs32_fetch
  import hs32_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter hs32_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mreq_valid_o,
  input  logic        mreq_ready_i,
  output logic [31:0] mreq_addr_o,
  input  logic        mresp_valid_i,
  input  logic [31:0] mresp_data_i,
  input  logic        mresp_err_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] op_o,
  output logic        banksel_o,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        flush_bank_i,
  input  logic        halt_i,
  output logic        err_o
`ifdef HS32_FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_o,
  output logic [15:0] perf_flush_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  hs32_fstate_t  r_state;
  hs32_addr_t    r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic          r_bank;

  logic [CW-1:0] w_count;
  logic [31:0]   w_head;
  logic [CW:0]   w_used;
  logic          w_req;
  logic          w_pop;
  logic          w_live;
  logic          w_push;
  logic          w_fault;

  // r_out counts every request in flight, including the stale ones r_drop will discard.
  assign w_used  = {1'b0, w_count} + {1'b0, r_out};
  assign mreq_valid_o = reset && (r_state == RUN) && !flush_i && (w_used < (CW+1)'(DEPTH));
  assign mreq_addr_o  = r_pc;
  assign w_req   = mreq_valid_o && mreq_ready_i;
  assign w_pop   = valid_o && ready_i;
  assign w_live  = mresp_valid_i && (r_drop == '0) && (r_state != ERR);
  assign w_push  = w_live && !mresp_err_i && !flush_i;
  assign w_fault = w_live && mresp_err_i && !flush_i;

  hs32_fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (mresp_data_i),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_out   <= '0;
      r_drop  <= '0;
      r_bank  <= 1'b0;
    end else begin
      r_out <= r_out + CW'(w_req) - CW'(mresp_valid_i);
      if (flush_i) begin
        r_state <= halt_i ? HALT : RUN;
        r_pc    <= flush_pc_i & ~hs32_addr_t'(3);
        r_bank  <= flush_bank_i;
        r_drop  <= r_out - CW'(mresp_valid_i);
      end else begin
        if (mresp_valid_i && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_req) r_pc <= r_pc + hs32_addr_t'(HS32_INSN_BYTES);
        if (w_fault) r_state <= ERR;
        else if ((r_state == RUN) && halt_i) r_state <= HALT;
        else if ((r_state == HALT) && !halt_i) r_state <= RUN;
      end
    end
  end

  assign valid_o   = (w_count != '0);
  assign op_o      = w_head;
  assign banksel_o = r_bank;
  assign err_o     = (r_state == ERR) && (w_count == '0);

`ifdef HS32_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_o <= '0;
      perf_flush_o <= '0;
    end else begin
      if (ready_i && !valid_o && (r_state == RUN) && (perf_stall_o != '1))
        perf_stall_o <= perf_stall_o + 32'd1;
      if (flush_i && (perf_flush_o != '1))
        perf_flush_o <= perf_flush_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hs32_fetch.sv
// Randomized self-checking bench for hs32_fetch against a transaction-level fetch model.
module tb_hs32_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mreq_valid_o;
  logic        mreq_ready_i;
  logic [31:0] mreq_addr_o;
  logic        mresp_valid_i;
  logic [31:0] mresp_data_i;
  logic        mresp_err_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] op_o;
  logic        banksel_o;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        flush_bank_i;
  logic        halt_i;
  logic        err_o;
`ifdef HS32_FETCH_PERF_EN
  logic [31:0] perfStall;
  logic [15:0] perfFlush;
`endif

  always #5 clk = ~clk;

  hs32_fetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mreq_valid_o  (mreq_valid_o),
    .mreq_ready_i  (mreq_ready_i),
    .mreq_addr_o   (mreq_addr_o),
    .mresp_valid_i (mresp_valid_i),
    .mresp_data_i  (mresp_data_i),
    .mresp_err_i   (mresp_err_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .op_o          (op_o),
    .banksel_o     (banksel_o),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .flush_bank_i  (flush_bank_i),
    .halt_i        (halt_i),
    .err_o         (err_o)
`ifdef HS32_FETCH_PERF_EN
    ,
    .perf_stall_o  (perfStall),
    .perf_flush_o  (perfFlush)
`endif
  );

  // Each in-flight read remembers which redirect epoch issued it.
  typedef struct packed {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] expq[$];
  int          epoch;
  logic [31:0] mPc;
  logic        mBank;
  int          mMode;
  int          cyc;

  int pReady, pMemReady, pResp, pFlush, pHalt, pErr, maxLat;
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    pend.delete();
    expq.delete();
    epoch = 0;
    mPc   = 32'h0;
    mBank = 1'b0;
    mMode = 0;
  endtask

  task automatic idleInputs();
    mreq_ready_i  = 1'b0;
    mresp_valid_i = 1'b0;
    mresp_data_i  = 32'h0;
    mresp_err_i   = 1'b0;
    ready_i       = 1'b0;
    flush_i       = 1'b0;
    flush_pc_i    = 32'h0;
    flush_bank_i  = 1'b0;
    halt_i        = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    idleInputs();
    modelReset();
    #1;
    checkOutput("rst_mreq_valid", mreq_valid_o, 0);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_banksel", banksel_o, 0);
    checkOutput("rst_addr", mreq_addr_o, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One random cycle: drive at negedge, check outputs, then advance the model at posedge.
  task automatic applyStimulus();
    logic expReq, doReq, doPop, goErr;
    req_t r;
    int lat;
    @(negedge clk);
    ready_i      = ($urandom_range(0, 99) < pReady);
    mreq_ready_i = ($urandom_range(0, 99) < pMemReady);
    flush_i      = ($urandom_range(0, 99) < pFlush);
    flush_pc_i   = ($urandom_range(0, 3) == 0) ? 32'h0000_1003 : $urandom;
    flush_bank_i = $urandom_range(0, 1);
    if ($urandom_range(0, 99) < pHalt) halt_i = ~halt_i;
    if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < pResp) begin
      mresp_valid_i = 1'b1;
      mresp_data_i  = pend[0].addr ^ 32'hA5A5_0000;
      mresp_err_i   = ($urandom_range(0, 99) < pErr);
    end else begin
      mresp_valid_i = 1'b0;
      mresp_data_i  = $urandom;
      mresp_err_i   = $urandom_range(0, 1);
    end
    #1;
    expReq = (mMode == 0) && !flush_i && ((expq.size() + pend.size()) < DEPTH);
    checkOutput("mreq_valid", mreq_valid_o, expReq);
    checkOutput("mreq_addr", mreq_addr_o, mPc);
    checkOutput("valid", valid_o, expq.size() != 0);
    if (expq.size() != 0) checkOutput("op", op_o, expq[0]);
    checkOutput("banksel", banksel_o, mBank);
    checkOutput("err", err_o, (mMode == 2) && (expq.size() == 0));
    doReq = expReq && mreq_ready_i;
    doPop = (expq.size() != 0) && ready_i;
    @(posedge clk);
    cyc++;
    goErr = 1'b0;
    if (doPop) void'(expq.pop_front());
    if (mresp_valid_i) begin
      r = pend.pop_front();
      if (!flush_i && r.epoch == epoch && mMode != 2) begin
        if (mresp_err_i) goErr = 1'b1;
        else expq.push_back(mresp_data_i);
      end
    end
    if (flush_i) begin
      expq.delete();
      epoch++;
      mBank = flush_bank_i;
      mPc   = flush_pc_i & 32'hFFFF_FFFC;
      mMode = halt_i ? 1 : 0;
    end else begin
      if (doReq) begin
        lat = $urandom_range(1, maxLat);
        pend.push_back('{addr: mPc, epoch: epoch, due: cyc + lat - 1});
        mPc = mPc + 32'd4;
      end
      if (goErr) mMode = 2;
      else if (mMode == 0 && halt_i) mMode = 1;
      else if (mMode == 1 && !halt_i) mMode = 0;
    end
  endtask

  task automatic runPhase(input int n, input int rdy, input int mrdy, input int rsp,
                          input int fl, input int hl, input int er, input int lat);
    pReady = rdy; pMemReady = mrdy; pResp = rsp;
    pFlush = fl;  pHalt = hl;       pErr = er; maxLat = lat;
    if (hl == 0) halt_i = 1'b0;
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    cyc   = 0;
    reset = 1'b0;
    idleInputs();
    modelReset();
    doReset();
    runPhase(200, 100, 100, 100, 0, 0, 0, 1);
    runPhase(30,  0,   100, 100, 0, 0, 0, 1);
    runPhase(300, 50,  100, 100, 0, 0, 0, 2);
    runPhase(600, 60,  80,  70,  10, 0, 0, 3);
    runPhase(600, 70,  90,  80,  3, 0, 5, 2);
    runPhase(600, 60,  80,  80,  2, 5, 0, 3);
    runPhase(1000, 50, 70,  70,  4, 4, 3, 4);
    doReset();
    runPhase(300, 60,  80,  80,  4, 4, 3, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
